// File: rtl/sdram_wr_arbiter.sv
// Two-port write arbiter in front of the SDRAM controller write interface.
// Port A (draw path) and port B (photon capture) share one registered write transaction at a time.
module sdram_wr_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 4095,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              iReqA,
    input  logic [ADDR_W-1:0] iAddrA,
    input  logic [DATA_W-1:0] iDataA,
    output logic              oDoneA,
    input  logic              iReqB,
    input  logic [ADDR_W-1:0] iAddrB,
    input  logic [DATA_W-1:0] iDataB,
    output logic              oDoneB,
    output logic [ADDR_W-1:0] oSDRAM_Wr_Addr,
    output logic [DATA_W-1:0] oSDRAM_Wr_Data,
    output logic              oSDRAM_Wr_Req,
    input  logic              iSDRAM_Wr_Done,
    output logic [1:0]        oGrant,
    output logic              oTimeoutErr
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_b_q, last_b_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [1:0]        grant_q, grant_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_a_q, done_a_d;
    logic              done_b_q, done_b_d;
    logic              terr_q, terr_d;

    logic [WD_W-1:0]   wd_inc;
    logic              timeout_hit;
    logic              pick_a;

    // The watchdog counts ISSUE cycles and aborts on the edge where it reaches TIMEOUT,
    // so the request stays high for exactly TIMEOUT cycles; it then rests at TIMEOUT.
    always_comb begin
        wd_inc      = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (wd_inc == WD_MAX);
        pick_a      = iReqA && (!iReqB || (FIXED_PRI != 0) || last_b_q);
    end

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        wd_d     = wd_q;
        grant_d  = grant_q;
        wr_req_d = wr_req_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        terr_d   = terr_q;

        case (state_q)
            ST_IDLE: begin
                if (en && (iReqA || iReqB)) begin
                    grant_d  = pick_a ? 2'b01 : 2'b10;
                    addr_d   = pick_a ? iAddrA : iAddrB;
                    data_d   = pick_a ? iDataA : iDataB;
                    wr_req_d = 1'b1;
                    wd_d     = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d = wd_inc;
                if (iSDRAM_Wr_Done || timeout_hit) begin
                    wr_req_d = 1'b0;
                    done_a_d = grant_q[0];
                    done_b_d = grant_q[1];
                    last_b_d = grant_q[1];
                    grant_d  = '0;
                    state_d  = ST_RELEASE;
                    if (!iSDRAM_Wr_Done) begin
                        terr_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                wr_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_b_q <= 1'b1;
            wd_q     <= '0;
            grant_q  <= '0;
            wr_req_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            wd_q     <= wd_d;
            grant_q  <= grant_d;
            wr_req_q <= wr_req_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            terr_q   <= terr_d;
        end
    end

    assign oDoneA         = done_a_q;
    assign oDoneB         = done_b_q;
    assign oSDRAM_Wr_Addr = addr_q;
    assign oSDRAM_Wr_Data = data_q;
    assign oSDRAM_Wr_Req  = wr_req_q;
    assign oGrant         = grant_q;
    assign oTimeoutErr    = terr_q;

endmodule
